// File: rtl/pulse_train_gen_if.sv
// Request/status bundle for pulse_train_gen. Master issues bursts;
// slave produces the pulse train and completion status.
interface pulse_train_gen_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             out;
  logic             busy;
  logic             done;

  modport master (output start, count, abort, input  out, busy, done);
  modport slave  (input  start, count, abort, output out, busy, done);
endinterface

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: one start request emits `count` pulses of
// HIGH_W cycles high / LOW_W cycles low on a registered output.
module pulse_train_gen #(
  parameter int HIGH_W = 4,
  parameter int LOW_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pulse_train_gen_if.slave  bus
);
  localparam int MAXW = (HIGH_W > LOW_W) ? HIGH_W : LOW_W;
  localparam int TW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t           r_state, w_state_n;
  logic [TW-1:0]    r_timer, w_timer_n;
  logic [CNT_W-1:0] r_rem,   w_rem_n;
  logic             r_out,   w_out_n;
  logic             r_busy,  w_busy_n;
  logic             r_done,  w_done_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_rem   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_rem   <= w_rem_n;
      r_out   <= w_out_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  // Abort wins over everything, including completion in the same cycle.
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_rem_n   = r_rem;
    w_out_n   = r_out;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    if (bus.abort) begin
      w_state_n = S_IDLE;
      w_out_n   = 1'b0;
      w_busy_n  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              w_state_n = S_HIGH;
              w_out_n   = 1'b1;
              w_busy_n  = 1'b1;
              w_timer_n = TW'(HIGH_W - 1);
              w_rem_n   = bus.count - CNT_W'(1);
            end else begin
              w_done_n  = 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (r_timer != '0) begin
            w_timer_n = r_timer - TW'(1);
          end else begin
            w_state_n = S_LOW;
            w_out_n   = 1'b0;
            w_timer_n = TW'(LOW_W - 1);
          end
        end
        S_LOW: begin
          if (r_timer != '0) begin
            w_timer_n = r_timer - TW'(1);
          end else if (r_rem != '0) begin
            w_state_n = S_HIGH;
            w_out_n   = 1'b1;
            w_timer_n = TW'(HIGH_W - 1);
            w_rem_n   = r_rem - CNT_W'(1);
          end else begin
            w_state_n = S_IDLE;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
          end
        end
        default: begin
          w_state_n = S_IDLE;
          w_out_n   = 1'b0;
          w_busy_n  = 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: vector table, directed corner sequences and
// a random run against a burst-window reference model.
module tb_pulse_train_gen;
  localparam int H = 3;
  localparam int L = 2;
  localparam int P = H + L;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pulse_train_gen_if #(.CNT_W(8)) bus ();

  pulse_train_gen #(.HIGH_W(H), .LOW_W(L), .CNT_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a burst is a window [m_b, m_b+m_len) of busy cycles.
  int m_act, m_b, m_len, m_zd;

  typedef struct {
    logic       s;
    logic [7:0] c;
    logic       a;
    logic       eo, eb, ed;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] c, input logic a);
    bus.start = s;
    bus.count = c;
    bus.abort = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_act = 0; m_b = 0; m_len = 0; m_zd = -1;
    cyc = 0;
  endtask

  task automatic model_step(input logic s, input logic [7:0] c, input logic a);
    bit idle;
    idle = !(m_act != 0 && cyc < m_b + m_len);
    if (a) begin
      m_act = 0;
    end else if (idle && s) begin
      if (c != 0) begin
        m_act = 1; m_b = cyc + 1; m_len = int'(c) * P;
      end else begin
        m_zd = cyc + 1;
      end
    end
  endtask

  task automatic model_check();
    logic eb, eo, ed;
    eb = (m_act != 0) && cyc >= m_b && cyc < m_b + m_len;
    eo = eb && ((cyc - m_b) % P) < H;
    ed = (cyc == m_zd) || (m_act != 0 && cyc == m_b + m_len);
    chk("rand_out",  bus.out,  eo);
    chk("rand_busy", bus.busy, eb);
    chk("rand_done", bus.done, ed);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, pulses;
    logic prev;
    logic s, a;
    logic [7:0] c;

    // inputs of one cycle, outputs expected in the following cycle
    tbl[0]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    drive(1'b0, 8'd0, 1'b0);
    #2;
    chk("reset_out",  bus.out,  1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);

    // vector table: abort mid-high, abort+start, zero count, back-to-back
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].c, tbl[i].a);
      tick();
      chk($sformatf("tbl%0d_out", i),  bus.out,  tbl[i].eo);
      chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].eb);
      chk($sformatf("tbl%0d_done", i), bus.done, tbl[i].ed);
    end

    // burst of 3 requested at cycle 10
    do_reset();
    for (int k = 0; k <= 28; k++) begin
      int t;
      drive(k == 10, (k == 10) ? 8'd3 : 8'd0, 1'b0);
      tick();
      t = k + 1;
      chk("burst_out", bus.out,
          (t >= 11 && t <= 13) || (t >= 16 && t <= 18) || (t >= 21 && t <= 23));
      chk("burst_busy", bus.busy, t >= 11 && t <= 25);
      chk("burst_done", bus.done, t == 26);
    end

    // start while busy is ignored
    do_reset();
    for (int k = 0; k <= 14; k++) begin
      int t;
      drive(k == 0 || k == 4 || k == 8, (k == 0) ? 8'd2 : 8'd7, 1'b0);
      tick();
      t = k + 1;
      chk("busy_start_out", bus.out, (t >= 1 && t <= 3) || (t >= 6 && t <= 8));
      chk("busy_start_busy", bus.busy, t >= 1 && t <= 10);
      chk("busy_start_done", bus.done, t == 11);
    end

    // async reset while in LOW
    do_reset();
    drive(1'b1, 8'd3, 1'b0);
    tick();
    drive(1'b0, 8'd0, 1'b0);
    tick(); tick(); tick();
    chk("pre_areset_busy", bus.busy, 1'b1);
    chk("pre_areset_out",  bus.out,  1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_busy", bus.busy, 1'b0);
    chk("areset_out",  bus.out,  1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("post_areset_busy", bus.busy, 1'b0);
      chk("post_areset_out",  bus.out,  1'b0);
      chk("post_areset_done", bus.done, 1'b0);
    end

    // count = 255 full-length burst
    drive(1'b1, 8'd255, 1'b0);
    tick();
    drive(1'b0, 8'd0, 1'b0);
    n = 1; pulses = 0; prev = 1'b0;
    while (bus.busy && n < 2000) begin
      if (bus.out && !prev) pulses++;
      prev = bus.out;
      tick();
      n++;
    end
    chk_int("max_burst_len", n, 1 + 255 * P);
    chk_int("max_burst_pulses", pulses, 255);
    chk("max_burst_done", bus.done, 1'b1);

    // random stimulus against the window model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      s = ($urandom_range(0, 5) == 0);
      c = 8'($urandom_range(0, 3));
      a = ($urandom_range(0, 40) == 0);
      model_step(s, c, a);
      drive(s, c, a);
      tick();
      model_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Generates a burst of evenly spaced output pulses on request: a single-cycle `start` produces `count` pulses of `HIGH_W` cycles high and `LOW_W` cycles low on a registered level output. It sits on the output side of the slot-machine datapath and drives LEDs and the buzzer. Its request inputs are the single-cycle `rise`/`fall` strobes produced by the input edge-detection stage, so all inputs are synchronous to `clk`.

## Interface
- `HIGH_W`, default 4: cycles `out` stays high per pulse; legal range ≥1.
- `LOW_W`, default 4: cycles `out` stays low after each pulse, including the last one; legal range ≥1.
- `CNT_W`, default 8: width of `count`.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request; sampled only in IDLE.
- `count`  input  CNT_W  number of pulses, unsigned; sampled together with `start`.
- `abort`  input  1  synchronous cancel, honoured in any state.
- `out`  output  1  registered pulse-train output.
- `busy`  output  1  registered; high while a burst is in progress.
- `done`  output  1  registered single-cycle strobe at burst completion.

## Operation
- Reset (asynchronous, `rst_n`=0): state IDLE; `out`=0, `busy`=0, `done`=0; timer=0; remaining=0.
- Timer width is `$clog2(max(HIGH_W,LOW_W))`, minimum 1 bit. The remaining-pulse counter is CNT_W bits. No arithmetic wraps in legal operation.
- States: IDLE, HIGH, LOW.
- IDLE:
  - `start`=1, `count`≠0, `abort`=0: go to HIGH; `out`←1; `busy`←1; timer←HIGH_W-1; remaining←`count`-1.
  - `start`=1, `count`=0, `abort`=0: stay in IDLE. `done`←1 for one cycle; `out` and `busy` stay 0.
- HIGH:
  - timer≠0: timer decrements.
  - timer=0: go to LOW; `out`←0; timer←LOW_W-1.
- LOW:
  - timer≠0: timer decrements.
  - timer=0, remaining≠0: go to HIGH; `out`←1; timer←HIGH_W-1; remaining decrements.
  - timer=0, remaining=0: go to IDLE; `busy`←0; `done`←1.
- `done` is 0 in every cycle other than the ones defined above.
- `start` while in HIGH or LOW is ignored. It is neither queued nor does it reload `count`.
- `abort`=1 in any state: next state IDLE; `out`←0; `busy`←0; `done`←0. Abort has priority over `start` and over normal completion in the same cycle.
- `count` is only looked at on the accepted `start` cycle. Later changes have no effect.
- `rst_n` asserted mid-burst: outputs clear immediately, without waiting for a clock edge. The burst does not resume after reset releases.

## Timing
- `start` is accepted at edge T0. `out` and `busy` rise at T0+1 (latency 1 cycle).
- Each pulse is exactly HIGH_W cycles high followed by LOW_W cycles low.
- A burst occupies `count`·(HIGH_W+LOW_W) cycles, starting at T0+1.
- `busy` falls and `done` pulses in the same cycle, T0+1+`count`·(HIGH_W+LOW_W). `done` lasts exactly 1 cycle.
- The earliest accepted back-to-back `start` is in the cycle where `done`=1, because the block is already in IDLE. The LOW_W gap guarantees that pulses from consecutive bursts never merge.
- `count`=0 request: `done` at T0+1; no `busy` cycle.
- Abort at edge Ta: `out`=0 and `busy`=0 from Ta+1. No `done` is generated.

## Test plan
- Reset, then burst:
  - Stimulus: `rst_n` low, release, then HIGH_W=3, LOW_W=2, `start` with `count`=3 at cycle 10.
  - Required: `out` high in cycles 11–13, 16–18 and 21–23; low otherwise.
  - Required: `busy` high in cycles 11–25; `done`=1 only in cycle 26.
- Zero-count request:
  - Stimulus: `start` with `count`=0 at cycle 5.
  - Required: `done`=1 in cycle 6 only; `out` and `busy` stay 0 throughout.
- Start while busy:
  - Stimulus: `count`=2 at cycle 0, then `start` with `count`=7 at cycles 4 and 8.
  - Required: exactly 2 pulses; `done` at cycle 11; the second request has no effect.
- Abort mid-high:
  - Stimulus: `count`=4; `abort` at cycle 2, while `out` is high.
  - Required: `out`=0 and `busy`=0 from cycle 3; no `done`.
  - Also: `abort`+`start` together in IDLE leaves `busy`=0.
- Back-to-back bursts:
  - Stimulus: second `start` with `count`=1 issued in the `done` cycle of a `count`=1 burst.
  - Required: the second pulse rises one cycle later; `out` is low for ≥LOW_W cycles between the two pulses.
- Asynchronous reset mid-LOW:
  - Stimulus: drop `rst_n` between clock edges while in LOW.
  - Required: `busy`=0 immediately, before the next edge. After release the block stays idle until a new `start`. `count`=255 burst completes in 255·(HIGH_W+LOW_W) cycles.
